apb_master_bridge: RTL and testbench

- Initiator end of the APB bus: accepts single read/write requests from an on-chip requester (core load/store unit or DMA) and drives the APB signals to peripheral slave interfaces (serial, GPIO, ...).
- Decodes the target slave from an address field and drives a one-hot PSEL.
- Sequences SETUP/ACCESS, waits on PREADY with a timeout, and returns read data and error status to the requester.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_master_bridge_if.sv | 28 ++
 rtl/apb_wait_timer.sv | 36 +++
 rtl/apb_master_bridge.sv | 177 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge.
//   APB_ADDR_W / APB_DATA_W : bus widths
//   APB_ERR_DATA            : read data returned on decode error or timeout
//   apb_state_t             : bridge sequencing states
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic [APB_DATA_W-1:0] APB_ERR_DATA = 32'hdeadbeef;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB bus between the bridge (master) and the peripheral slaves.
//   PADDR, PSEL, PENABLE, PWRITE, PWDATA : master -> slave
//   PRDATA, PREADY, PSLVERR              : slave -> master
interface apb_master_bridge_if #(
  parameter int NUM_SLV = 4
);
  import apb_pkg::*;

  logic [APB_ADDR_W-1:0] PADDR;
  logic [NUM_SLV-1:0]    PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Wait-state timer for the ACCESS phase.
//   clk, rst : clock, async active-high reset
//   clr      : zero the count (entry to SETUP)
//   en       : this cycle is an ACCESS cycle with PREADY low
//   expired  : this wait cycle is the TIMEOUT-th one; abort at the next edge
// TIMEOUT = 0 disables the timer (expired never asserts).
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Saturates at TIMEOUT so a stuck enable can never wrap the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the waits already seen; this cycle's wait makes it cnt + 1.
  assign expired = (TIMEOUT != 0) && en && ((int'({1'b0, cnt}) + 1) >= TIMEOUT);

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: takes single read/write requests from an on-chip requester,
// decodes the target slave from the address, runs the SETUP/ACCESS sequence
// with a PREADY timeout and returns read data plus error status.
//   clk, rst                      : clock, async active-high reset
//   req_valid/req_ready           : request handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata  : request fields, latched on accept
//   rsp_valid                     : one-cycle response pulse, no backpressure
//   rsp_rdata/rsp_err/rsp_timeout : response fields, held until next response
//   apb                           : APB master port
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int SLV_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [APB_ADDR_W-1:0] req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  apb_master_bridge_if.master   apb
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  apb_state_t            state_q;
  apb_state_t            state_d;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      req_idx;
  logic [APB_ADDR_W-1:0] req_win;
  logic                  dec_ok;
  logic                  accept;

  logic [NUM_SLV-1:0]    psel_d;
  logic                  penable_d;
  logic                  rsp_valid_d;
  logic [APB_DATA_W-1:0] rsp_rdata_d;
  logic                  rsp_err_d;
  logic                  rsp_timeout_d;

  logic                  timer_clr;
  logic                  timer_en;
  logic                  timer_expired;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // The whole address above SLV_LSB is compared, so windows past the last
  // slave become decode errors instead of aliasing onto a real slave.
  assign req_win = req_addr >> SLV_LSB;
  assign dec_ok  = req_win < APB_ADDR_W'(NUM_SLV);
  assign req_idx = req_addr[SLV_LSB +: IDX_W];

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus and response outputs are computed for the next cycle here and
  // registered below, so every output except req_ready comes from a flop.
  always_comb begin
    state_d       = state_q;
    psel_d        = '0;
    penable_d     = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_ok) begin
            state_d   = SETUP;
            psel_d    = NUM_SLV'(1) << req_idx;
            timer_clr = 1'b1;
          end else begin
            state_d = DECERR;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        psel_d    = NUM_SLV'(1) << idx_q;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (apb.PREADY) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = apb.PWRITE ? '0 : apb.PRDATA;
          rsp_err_d     = apb.PSLVERR;
          rsp_timeout_d = 1'b0;
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            state_d       = IDLE;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = APB_ERR_DATA;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end else begin
            psel_d    = NUM_SLV'(1) << idx_q;
            penable_d = 1'b1;
          end
        end
      end

      DECERR: begin
        state_d       = IDLE;
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = APB_ERR_DATA;
        rsp_err_d     = 1'b1;
        rsp_timeout_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // PADDR/PWRITE/PWDATA load only on accept and otherwise keep their value,
  // including through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      apb.PADDR   <= '0;
      apb.PWRITE  <= 1'b0;
      apb.PWDATA  <= '0;
      apb.PSEL    <= '0;
      apb.PENABLE <= 1'b0;
      idx_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        apb.PADDR  <= req_addr;
        apb.PWRITE <= req_write;
        apb.PWDATA <= req_wdata;
        idx_q      <= req_idx;
      end
      apb.PSEL    <= psel_d;
      apb.PENABLE <= penable_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: stimulus pushes the expected
// response of each request into a queue, a monitor pops and compares on
// rsp_valid and checks APB bus behaviour every cycle.
module tb_apb_master_bridge;

  localparam int NUM_SLV = 4;
  localparam int SLV_LSB = 12;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          lat;
    int          t;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  apb_master_bridge_if #(.NUM_SLV(NUM_SLV)) bus ();

  apb_master_bridge #(
    .NUM_SLV (NUM_SLV),
    .SLV_LSB (SLV_LSB),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  exp_t exp_q[$];

  // Plan for the transfer in flight (only one at a time).
  logic [31:0] cur_addr  = '0;
  logic        cur_write = 1'b0;
  logic [31:0] cur_wdata = '0;
  int          cur_wait  = 0;
  logic        cur_serr  = 1'b0;
  logic [31:0] cur_prd   = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [3:0] psel_of(input logic [31:0] a);
    logic [31:0] win;
    win = a >> SLV_LSB;
    if (win < NUM_SLV) return 4'(1 << win);
    return 4'b0000;
  endfunction

  // Reference: what the requester should see, and how many cycles after the
  // request cycle T the response should arrive.
  function automatic exp_t model(input logic wr, input logic [31:0] a,
                                 input int w, input logic serr, input logic [31:0] prd);
    exp_t e;
    e.t = 0;
    if ((a >> SLV_LSB) >= NUM_SLV) begin
      e.rdata = 32'hdeadbeef; e.err = 1'b1; e.to = 1'b0; e.lat = 2;
    end else if (w >= TIMEOUT) begin
      e.rdata = 32'hdeadbeef; e.err = 1'b1; e.to = 1'b1; e.lat = 2 + TIMEOUT;
    end else begin
      e.rdata = wr ? 32'h0 : prd; e.err = serr; e.to = 1'b0; e.lat = 3 + w;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input int w, input logic serr, input logic [31:0] prd);
    exp_t e;
    int guard;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("req_ready_wait", req_ready, 1'b1);
      return;
    end
    cur_addr = a; cur_write = wr; cur_wdata = wd;
    cur_wait = w; cur_serr = serr; cur_prd = prd;
    e = model(wr, a, w, serr, prd);
    e.t = cyc;
    exp_q.push_back(e);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom);
    req_addr  = $urandom; req_wdata = $urandom;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  // Slave model: PREADY low for cur_wait ACCESS cycles, then high. Outside
  // ACCESS the slave inputs carry noise the bridge must ignore.
  int acc_k = 0;
  always @(negedge clk) begin
    if (bus.PSEL != 0 && bus.PENABLE) begin
      bus.PREADY  = (acc_k >= cur_wait);
      bus.PRDATA  = cur_prd;
      bus.PSLVERR = cur_serr;
      acc_k++;
    end else begin
      bus.PREADY  = 1'($urandom);
      bus.PSLVERR = 1'($urandom);
      bus.PRDATA  = $urandom;
      acc_k = 0;
    end
  end

  // Monitor.
  logic prev_psel = 1'b0;
  logic have_last = 1'b0;
  exp_t last_e;
  exp_t got_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_psel = 1'b0;
      have_last = 1'b0;
    end else begin
      chk("psel_onehot0", $onehot0(bus.PSEL), 1'b1);
      if (bus.PENABLE) chk("penable_without_psel", bus.PSEL != 0, 1'b1);
      if (bus.PSEL != 0) begin
        chk("psel", bus.PSEL, psel_of(cur_addr));
        chk("paddr", bus.PADDR, cur_addr);
        chk("pwrite", bus.PWRITE, cur_write);
        chk("pwdata", bus.PWDATA, cur_wdata);
        chk(prev_psel ? "penable_access" : "penable_setup", bus.PENABLE, prev_psel);
      end
      if (rsp_valid) begin
        chk("rsp_expected", exp_q.size() != 0, 1'b1);
        chk("req_ready_with_rsp", req_ready, 1'b1);
        if (exp_q.size() != 0) begin
          got_e = exp_q.pop_front();
          chk("rsp_latency", cyc - got_e.t, got_e.lat);
          chk("rsp_rdata", rsp_rdata, got_e.rdata);
          chk("rsp_err", rsp_err, got_e.err);
          chk("rsp_timeout", rsp_timeout, got_e.to);
          last_e = got_e;
          have_last = 1'b1;
        end
      end else if (have_last) begin
        chk("rsp_rdata_hold", rsp_rdata, last_e.rdata);
        chk("rsp_err_hold", rsp_err, last_e.err);
        chk("rsp_timeout_hold", rsp_timeout, last_e.to);
      end
      prev_psel = (bus.PSEL != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          w;
    int          r;
    int          guard;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 1'b0);
    chk("reset_psel", bus.PSEL, 4'b0);
    chk("reset_penable", bus.PENABLE, 1'b0);
    chk("reset_paddr", bus.PADDR, 32'h0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", {rsp_err, rsp_timeout}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", req_ready, 1'b1);

    // Directed cases.
    issue(1'b1, 32'h0000_1004, 32'h0000_00a5, 0, 1'b0, 32'h0);
    wait_drain();
    chk("paddr_retained_idle", bus.PADDR, 32'h0000_1004);
    chk("pwdata_retained_idle", bus.PWDATA, 32'h0000_00a5);
    chk("psel_idle", bus.PSEL, 4'b0);
    issue(1'b0, 32'h0000_2008, 32'h0, 3, 1'b0, 32'h1234_5678);
    wait_drain();
    issue(1'b0, 32'h0000_0010, 32'h0, 0, 1'b1, 32'h0bad_0bad);
    wait_drain();
    issue(1'b0, 32'h0000_4000, 32'h0, 0, 1'b0, 32'h0);
    wait_drain();
    issue(1'b0, 32'h0000_3010, 32'h0, 15, 1'b0, 32'hcafe_f00d);
    wait_drain();
    issue(1'b1, 32'h0000_3014, 32'h1111_2222, 16, 1'b0, 32'h0);
    wait_drain();
    issue(1'b0, 32'h0000_1000, 32'h0, 40, 1'b0, 32'h0);
    wait_drain();
    issue(1'b0, 32'h0000_2000, 32'h0, 1, 1'b0, 32'h7777_0001);
    wait_drain();

    // Randomized traffic, issued as soon as the bridge is ready.
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 5) << SLV_LSB) | ($urandom & 32'h0000_0ffc);
      if ($urandom_range(0, 9) == 0) a[31] = 1'b1;
      r = $urandom_range(0, 9);
      if (r < 6)      w = $urandom_range(0, 3);
      else if (r < 8) w = $urandom_range(4, 8);
      else            w = $urandom_range(14, 18);
      issue(1'($urandom), a, $urandom, w, ($urandom_range(0, 3) == 0), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();

    // Reset in the middle of ACCESS.
    issue(1'b0, 32'h0000_3000, 32'h0, 10, 1'b0, 32'h5555_aaaa);
    guard = 0;
    while (!bus.PENABLE && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("reached_access", bus.PENABLE, 1'b1);
    rst = 1'b1;
    #1;
    chk("midreset_psel", bus.PSEL, 4'b0);
    chk("midreset_penable", bus.PENABLE, 1'b0);
    chk("midreset_paddr", bus.PADDR, 32'h0);
    chk("midreset_rsp_valid", rsp_valid, 1'b0);
    chk("midreset_req_ready", req_ready, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", rsp_valid, 1'b0);
    end
    issue(1'b0, 32'h0000_3004, 32'h0, 2, 1'b0, 32'h0a0b_0c0d);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
